// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker pipeline.
//   mptw_walking_e      : walking decision carried by a transaction
//   plb_lookup_req_t    : PLB lookup key {sdid, spa, access_type}, driven on the cache address
//   mptw_transaction_t  : pipeline transaction passed between walker stages
//   plb_track_entry_t   : one in-order tracker slot of the PLB lookup stage
package mpt_pkg;

   typedef enum logic {
      MPT_WALKING_DO   = 1'b0,
      MPT_WALKING_SKIP = 1'b1
   } mptw_walking_e;

   typedef struct packed {
      logic [5:0]  sdid;
      logic [19:0] spa;
      logic [1:0]  access_type;
   } plb_lookup_req_t;

   typedef struct packed {
      logic [2:0]    tag;
      logic [5:0]    sdid;
      logic [19:0]   spa;
      logic [1:0]    access_type;
      mptw_walking_e walking;
   } mptw_transaction_t;

   typedef struct packed {
      mptw_transaction_t txn;
      logic              hit;
      logic              rsp_v;
   } plb_track_entry_t;

   localparam int unsigned PLB_TRANSACTION_DATA_WIDTH = 8;
   localparam int unsigned PLB_TRANSACTION_ADDR_WIDTH = $bits(plb_lookup_req_t);

   function automatic plb_lookup_req_t plb_req_from_txn(input mptw_transaction_t t);
      plb_lookup_req_t r;
      r.sdid        = t.sdid;
      r.spa         = t.spa;
      r.access_type = t.access_type;
      return r;
   endfunction

   function automatic mptw_transaction_t mptw_resolve(input mptw_transaction_t t,
                                                      input logic              hit);
      mptw_transaction_t r;
      r         = t;
      r.walking = hit ? MPT_WALKING_SKIP : MPT_WALKING_DO;
      return r;
   endfunction

endpackage

// File: rtl/plb_lookup_tracker.sv
// In-order tracker for granted PLB lookups.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push, push_txn  : store a newly granted transaction at the tail (response pending)
//   respond, respond_hit : cache response; fills the oldest pending entry, or is
//                     swallowed while stale responses from a flush are still due
//   pop             : retire the head entry
//   flush           : empty the tracker; pending lookups become stale responses to drain
//   head_valid      : head entry exists and holds its response
//   head_txn, head_hit : head entry contents
//   count, drain_cnt: tracked entries / stale responses still expected
//   orphan_rsp      : response arrived with nothing pending and nothing to drain
module plb_lookup_tracker
   import mpt_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  mptw_transaction_t        push_txn,
   input  logic                     respond,
   input  logic                     respond_hit,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     head_valid,
   output mptw_transaction_t        head_txn,
   output logic                     head_hit,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   drain_cnt,
   output logic                     orphan_rsp
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   plb_track_entry_t entry_q [DEPTH];
   logic [PW-1:0]    tail_q, rsp_q, head_q;
   logic [CW-1:0]    count_q, pend_q, drain_q;
   logic             rsp_live, rsp_dead;
   logic [CW-1:0]    pend_nxt;

   always_comb begin
      rsp_dead   = respond && (drain_q != '0);
      rsp_live   = respond && (drain_q == '0) && (pend_q != '0);
      orphan_rsp = respond && (drain_q == '0) && (pend_q == '0);
      pend_nxt   = pend_q + CW'(push) - CW'(rsp_live);
   end

   // Slots keep stale rsp_v after a pop, so the head is only valid while count is non-zero.
   always_comb begin
      head_valid = (count_q != '0) && entry_q[head_q].rsp_v;
      head_txn   = entry_q[head_q].txn;
      head_hit   = entry_q[head_q].hit;
      count      = count_q;
      drain_cnt  = drain_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tail_q  <= '0;
         rsp_q   <= '0;
         head_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
         drain_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         if (push) begin
            entry_q[tail_q] <= '{txn: push_txn, hit: 1'b0, rsp_v: 1'b0};
         end
         if (rsp_live) begin
            entry_q[rsp_q].hit   <= respond_hit;
            entry_q[rsp_q].rsp_v <= 1'b1;
         end
         if (flush) begin
            // Every lookup still awaiting its response (including one granted
            // this cycle) turns into a stale response that must be discarded.
            tail_q  <= '0;
            rsp_q   <= '0;
            head_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            drain_q <= drain_q - CW'(rsp_dead) + pend_nxt;
         end else begin
            tail_q  <= tail_q + PW'(push);
            rsp_q   <= rsp_q + PW'(rsp_live);
            head_q  <= head_q + PW'(pop);
            count_q <= count_q + CW'(push) - CW'(pop);
            pend_q  <= pend_nxt;
            drain_q <= drain_q - CW'(rsp_dead);
         end
      end
   end

endmodule

// File: rtl/plb_lookup_stage_mo.sv
// Multi-outstanding PLB lookup stage of the MPT walker pipeline.
// Issues pipelined PLB reads keyed on {sdid, spa, access_type}; rdata[0] is the hit
// bit. Granted lookups are tracked in order and leave with walking = SKIP on a hit,
// DO on a miss.
//   clk_i, rst_ni                         : clock, asynchronous active-low reset
//   plb_lookup_slave_valid/ready/data     : upstream transaction (accepted on cache grant)
//   plb_lookup_master_valid/ready/data    : downstream transaction, walking resolved
//   plb_lookup_ctrl_flush                 : drop all tracked and in-flight lookups
//   plb_lookup_ctrl_stall                 : freeze issue and output
//   plb_cache_mem_req/gnt/addr            : read request channel
//   plb_cache_mem_we/be/wdata             : write side, unused (tied 0)
//   plb_cache_mem_valid/rdata             : in-order read responses
module plb_lookup_stage_mo
   import mpt_pkg::*;
#(
   parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH  = 32,
   parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = 32,
   parameter int unsigned MAX_OUTSTANDING            = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  plb_lookup_slave_valid,
   output logic                                  plb_lookup_slave_ready,
   input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  plb_lookup_slave_data,
   output logic                                  plb_lookup_master_valid,
   input  logic                                  plb_lookup_master_ready,
   output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] plb_lookup_master_data,
   input  logic                                  plb_lookup_ctrl_flush,
   input  logic                                  plb_lookup_ctrl_stall,
   output logic                                  plb_cache_mem_req,
   input  logic                                  plb_cache_mem_gnt,
   output logic [PLB_TRANSACTION_ADDR_WIDTH-1:0] plb_cache_mem_addr,
   output logic                                  plb_cache_mem_we,
   output logic                                  plb_cache_mem_be,
   output logic [PLB_TRANSACTION_DATA_WIDTH-1:0] plb_cache_mem_wdata,
   input  logic                                  plb_cache_mem_valid,
   input  logic [PLB_TRANSACTION_DATA_WIDTH-1:0] plb_cache_mem_rdata
);

   localparam int unsigned TXN_W = $bits(mptw_transaction_t);
   localparam int unsigned CW    = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned BW    = CW + 1;

   mptw_transaction_t in_txn, out_txn, head_txn;
   logic              head_valid, head_hit;
   logic              push, pop, orphan_rsp;
   logic [CW-1:0]     count, drain_cnt;
   logic [BW-1:0]     budget;
   logic              unused_rdata;

   // Stale responses still occupy cache slots, so they count against the issue budget.
   always_comb begin
      in_txn  = mptw_transaction_t'(plb_lookup_slave_data[TXN_W-1:0]);
      budget  = BW'(count) + BW'(drain_cnt);
      plb_cache_mem_req = rst_ni && plb_lookup_slave_valid && !plb_lookup_ctrl_stall &&
                          !plb_lookup_ctrl_flush && (budget < BW'(MAX_OUTSTANDING));
      plb_cache_mem_addr     = plb_req_from_txn(in_txn);
      plb_lookup_slave_ready = plb_cache_mem_req && plb_cache_mem_gnt;
      push                   = plb_lookup_slave_ready;
      plb_cache_mem_we       = 1'b0;
      plb_cache_mem_be       = 1'b0;
      plb_cache_mem_wdata    = '0;
   end

   always_comb begin
      plb_lookup_master_valid = head_valid && !plb_lookup_ctrl_stall;
      pop                     = plb_lookup_master_valid && plb_lookup_master_ready;
      out_txn                 = mptw_resolve(head_txn, head_hit);
      plb_lookup_master_data  = '0;
      plb_lookup_master_data[TXN_W-1:0] = out_txn;
   end

   assign unused_rdata = ^plb_cache_mem_rdata[PLB_TRANSACTION_DATA_WIDTH-1:1];

   plb_lookup_tracker #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tracker (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push        (push),
      .push_txn    (in_txn),
      .respond     (plb_cache_mem_valid),
      .respond_hit (plb_cache_mem_rdata[0]),
      .pop         (pop),
      .flush       (plb_lookup_ctrl_flush),
      .head_valid  (head_valid),
      .head_txn    (head_txn),
      .head_hit    (head_hit),
      .count       (count),
      .drain_cnt   (drain_cnt),
      .orphan_rsp  (orphan_rsp)
   );

   // A response with nothing pending and nothing to drain breaks the cache protocol; it is ignored.
   a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) !orphan_rsp);

   a_issue_budget: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    budget <= BW'(MAX_OUTSTANDING));

endmodule
